// File: rtl/cannon_array.sv
`default_nettype none
// ============================================================================
//  Module   : cannon_array
//  Purpose  : N x N Cannon-algorithm matrix multiplier, S = A * B.
//             Operands are captured with the Cannon pre-skew, then shifted
//             toroidally (A left, B up) for N multiply-accumulate steps.
//             Start/busy/done handshake; the result is held until the next
//             job completes.
//  Options  : CANNON_SIGNED_EN - two's-complement operands and results
//             (undefined: unsigned arithmetic).
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module cannon_array #(
   parameter int N    = 4,
   parameter int DW   = 8,
   parameter int ACCW = 2*DW + $clog2(N) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [N*N*DW-1:0]     a_flat,
   input  logic [N*N*DW-1:0]     b_flat,
   output logic                  busy,
   output logic                  done,
   output logic [N*N*ACCW-1:0]   s_flat
);

   localparam int            CW     = $clog2(N);
   localparam logic [CW-1:0] C_LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q;
   logic                  done_q;
   logic [N*N*DW-1:0]     a_q;
   logic [N*N*DW-1:0]     b_q;
   logic [N*N*ACCW-1:0]   acc_q;
   logic [N*N*ACCW-1:0]   s_q;
   logic [N*N*ACCW-1:0]   prod_ext;

   // Per-PE product, widened to the accumulator width before accumulation.
   for (genvar k = 0; k < N*N; k++) begin : g_pe
      logic [2*DW-1:0] op_a;
      logic [2*DW-1:0] op_b;
      logic [2*DW-1:0] prod;
`ifdef CANNON_SIGNED_EN
      assign op_a = {{DW{a_q[k*DW + DW-1]}}, a_q[k*DW +: DW]};
      assign op_b = {{DW{b_q[k*DW + DW-1]}}, b_q[k*DW +: DW]};
      assign prod = op_a * op_b;
      assign prod_ext[k*ACCW +: ACCW] = {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
`else
      assign op_a = {{DW{1'b0}}, a_q[k*DW +: DW]};
      assign op_b = {{DW{1'b0}}, b_q[k*DW +: DW]};
      assign prod = op_a * op_b;
      assign prod_ext[k*ACCW +: ACCW] = {{(ACCW-2*DW){1'b0}}, prod};
`endif
   end

   // Control state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: IDLE -> CALC on start, N MAC steps, one FIN step.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = CALC;
         CALC:    if (cnt_q == C_LAST) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath: skewed operand load, MAC with toroidal shift, result capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         acc_q  <= '0;
         s_q    <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  // PE(i,j) gets A[i][(i+j)%N] and B[(i+j)%N][j].
                  for (int i = 0; i < N; i++) begin
                     for (int j = 0; j < N; j++) begin
                        a_q[(i*N+j)*DW +: DW] <= a_flat[(i*N + (i+j)%N)*DW +: DW];
                        b_q[(i*N+j)*DW +: DW] <= b_flat[(((i+j)%N)*N + j)*DW +: DW];
                     end
                  end
                  acc_q <= '0;
                  cnt_q <= '0;
               end
            end
            CALC: begin
               acc_q <= acc_q + '0;
               for (int i = 0; i < N; i++) begin
                  for (int j = 0; j < N; j++) begin
                     acc_q[(i*N+j)*ACCW +: ACCW] <= acc_q[(i*N+j)*ACCW +: ACCW]
                                                  + prod_ext[(i*N+j)*ACCW +: ACCW];
                     // A moves one PE left, B one PE up, both wrapping.
                     a_q[(i*N+j)*DW +: DW] <= a_q[(i*N + (j+1)%N)*DW +: DW];
                     b_q[(i*N+j)*DW +: DW] <= b_q[(((i+1)%N)*N + j)*DW +: DW];
                  end
               end
               cnt_q <= cnt_q + 1'b1;
            end
            FIN: begin
               s_q    <= acc_q;
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = done_q;
   assign s_flat = s_q;

endmodule
`default_nettype wire

// File: tb/tb_cannon_array.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cannon_array
//  Purpose  : Self-checking bench for cannon_array (N=4/DW=8 main instance
//             with a matrix-product reference model, plus an N=3/DW=4
//             instance for the non-power-of-two wrap-around).
//  Options  : CANNON_SIGNED_EN selects signed expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cannon_array;

   localparam int N    = 4;
   localparam int DW   = 8;
   localparam int ACCW = 2*DW + $clog2(N) + 1;
   localparam int MW   = N*N*DW;
   localparam int SW   = N*N*ACCW;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [MW-1:0] a_flat, b_flat;
   logic          busy, done;
   logic [SW-1:0] s_flat;

   logic          start3;
   logic [35:0]   a3, b3;
   logic          busy3, done3;
   logic [98:0]   s3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cannon_array #(.N(N), .DW(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .a_flat(a_flat), .b_flat(b_flat),
      .busy(busy), .done(done), .s_flat(s_flat)
   );

   cannon_array #(.N(3), .DW(4)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .a_flat(a3), .b_flat(b3),
      .busy(busy3), .done(done3), .s_flat(s3)
   );

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic longint el(input logic [MW-1:0] m, input int r, input int c);
      logic [DW-1:0] u;
      u = m[(r*N+c)*DW +: DW];
`ifdef CANNON_SIGNED_EN
      return longint'($signed(u));
`else
      return longint'(u);
`endif
   endfunction

   function automatic logic [SW-1:0] matmul(input logic [MW-1:0] a, input logic [MW-1:0] b);
      logic [SW-1:0] r;
      longint        s;
      r = '0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            s = 0;
            for (int k = 0; k < N; k++) s += el(a, i, k) * el(b, k, j);
            r[(i*N+j)*ACCW +: ACCW] = s[ACCW-1:0];
         end
      end
      return r;
   endfunction

   function automatic logic [MW-1:0] rnd_mat();
      logic [MW-1:0] m;
      int            mode;
      mode = int'($urandom_range(0, 7));
      for (int k = 0; k < N*N; k++) begin
         case (mode)
            0:       m[k*DW +: DW] = '1;
            1:       m[k*DW +: DW] = {1'b1, {(DW-1){1'b0}}};
            default: m[k*DW +: DW] = DW'($urandom);
         endcase
      end
      return m;
   endfunction

   function automatic logic [MW-1:0] fill(input logic [DW-1:0] v);
      logic [MW-1:0] m;
      for (int k = 0; k < N*N; k++) m[k*DW +: DW] = v;
      return m;
   endfunction

   // Inputs as seen by the DUT at each rising edge.
   logic          c_rst = 1'b1, c_start = 1'b0;
   logic [MW-1:0] c_a = '0, c_b = '0;
   always @(posedge clk) begin
      c_rst   <= rst;
      c_start <= start;
      c_a     <= a_flat;
      c_b     <= b_flat;
   end

   // Job timeline: a job lasts N+1 edges after its accepting edge; the
   // product of the captured operands appears together with done.
   bit            m_act  = 1'b0;
   int            m_k    = 0;
   bit            m_done = 1'b0;
   logic [SW-1:0] m_s    = '0;
   logic [MW-1:0] cap_a, cap_b;

   always @(negedge clk) begin
      if (c_rst) begin
         m_act = 1'b0; m_k = 0; m_done = 1'b0; m_s = '0;
      end else begin
         m_done = 1'b0;
         if (!m_act) begin
            if (c_start) begin
               m_act = 1'b1; m_k = 0; cap_a = c_a; cap_b = c_b;
            end
         end else begin
            m_k++;
            if (m_k == N+1) begin
               m_s    = matmul(cap_a, cap_b);
               m_done = 1'b1;
               m_act  = 1'b0;
            end
         end
      end
      chk("busy", 512'(busy), 512'(m_act));
      chk("done", 512'(done), 512'(m_done));
      chk("s_flat", 512'(s_flat), 512'(m_s));
   end

   // ---------------- stimulus ----------------
   task automatic run_job(input logic [MW-1:0] a, input logic [MW-1:0] b, output int lat);
      @(posedge clk); #1;
      a_flat = a; b_flat = b; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      lat = -1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done) begin lat = c; break; end
      end
   endtask

   logic [MW-1:0]   ident, bseq;
   logic [ACCW-1:0] e;
   int              lat, last, t, nd;

   initial begin
      rst = 1'b1; start = 1'b0; a_flat = '0; b_flat = '0;
      start3 = 1'b0; a3 = '0; b3 = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_busy", 512'(busy), 512'(0));
      chk("reset_s", 512'(s_flat), 512'(0));

      // Identity times B: S = B, done 5 cycles after the start edge.
      ident = '0; bseq = '0;
      for (int i = 0; i < N; i++) begin
         ident[(i*N+i)*DW +: DW] = DW'(1);
         for (int j = 0; j < N; j++) bseq[(i*N+j)*DW +: DW] = DW'(4*i + j);
      end
      run_job(ident, bseq, lat);
      chk("ident_latency", 512'(lat), 512'(5));
      chk("ident_busy_at_done", 512'(busy), 512'(0));
      for (int k = 0; k < N*N; k++)
         chk("ident_elem", 512'(s_flat[k*ACCW +: ACCW]), 512'(k));

      // All-ones operands.
      run_job(fill('1), fill('1), lat);
`ifdef CANNON_SIGNED_EN
      e = ACCW'(4);
`else
      e = ACCW'(260100);
`endif
      for (int k = 0; k < N*N; k += 5)
         chk("ones_elem", 512'(s_flat[k*ACCW +: ACCW]), 512'(e));

`ifdef CANNON_SIGNED_EN
      run_job(fill(8'h80), fill(8'h80), lat);
      for (int k = 0; k < N*N; k += 3)
         chk("neg128_elem", 512'(s_flat[k*ACCW +: ACCW]), 512'(65536));
      run_job(fill(8'hFF), fill(8'h01), lat);
      e = '1; e[1:0] = 2'b00;
      for (int k = 0; k < N*N; k += 3)
         chk("minus4_elem", 512'(s_flat[k*ACCW +: ACCW]), 512'(e));
`endif

      // start held high: back-to-back jobs, A refreshed after every done.
      @(posedge clk); #1;
      a_flat = rnd_mat(); b_flat = rnd_mat(); start = 1'b1;
      last = -1; nd = 0;
      for (t = 0; t < 60; t++) begin
         @(negedge clk);
         if (done) begin
            if (last >= 0) chk("b2b_spacing", 512'(t - last), 512'(N + 2));
            last = t; nd++;
            a_flat = rnd_mat();
            if (nd == 4) break;
         end
      end
      start = 1'b0;
      chk("b2b_count", 512'(nd), 512'(4));
      repeat (3) @(posedge clk);

      // start pulses mid-CALC with different operands are ignored.
      @(posedge clk); #1;
      a_flat = rnd_mat(); b_flat = rnd_mat(); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1 start = 1'b1; a_flat = rnd_mat();
      @(posedge clk); #1 start = 1'b0;
      repeat (N + 4) @(posedge clk);

      // Reset on the third CALC edge of a second job.
      run_job(ident, ident, lat);
      @(posedge clk); #1;
      a_flat = rnd_mat(); b_flat = rnd_mat(); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", 512'(busy), 512'(0));
      chk("rst_done", 512'(done), 512'(0));
      chk("rst_s", 512'(s_flat), 512'(0));
      nd = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("rst_no_done", 512'(nd), 512'(0));
      run_job(rnd_mat(), rnd_mat(), lat);
      chk("post_rst_latency", 512'(lat), 512'(5));

      // Randomised traffic with occasional reset.
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         start  = ($urandom_range(0, 2) == 0);
         rst    = ($urandom_range(0, 59) == 0);
         a_flat = rnd_mat();
         b_flat = rnd_mat();
      end
      @(posedge clk); #1 rst = 1'b0; start = 1'b0;

      // N=3, DW=4: A[i][j]=i+j, B[i][j]=i*j.
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) begin
            a3[(i*3+j)*4 +: 4] = 4'(i + j);
            b3[(i*3+j)*4 +: 4] = 4'(i * j);
         end
      @(posedge clk); #1 start3 = 1'b1;
      @(posedge clk); #1 start3 = 1'b0;
      lat = -1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done3) begin lat = c; break; end
      end
      chk("n3_latency", 512'(lat), 512'(4));
      begin
         int exp3 [9] = '{0, 5, 10, 0, 8, 16, 0, 11, 22};
         for (int k = 0; k < 9; k++)
            chk("n3_elem", 512'(s3[k*11 +: 11]), 512'(exp3[k]));
      end

      repeat (4) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
